gsensor_spi_responder: RTL and testbench
========================================

GSENSOR_SPI_RESPONDER -- requirements
Module: gsensor_spi_responder

Interface
REQ-001 Parameter DEVID, default 8'hE5, value returned from register 0x00.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on spi_clk/spi_csn/spi_sdi.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 spi_clk  input  1  SPI clock from initiator, mode 3 (idles high).
REQ-006 spi_csn  input  1  chip select, active low.
REQ-007 spi_sdi  input  1  initiator-to-responder serial data, MSB first.
REQ-008 spi_sdo  output  1  responder-to-initiator serial data, MSB first.
REQ-009 sample_valid  input  1  one-cycle strobe: load sample_x/y/z into data registers.
REQ-010 sample_x, sample_y, sample_z  input  16 each  signed sample words.
REQ-011 wr_valid  output  1  one-cycle strobe per committed SPI register write.
REQ-012 wr_addr  output  6  address of committed write; valid with wr_valid.
REQ-013 wr_data  output  8  data of committed write; valid with wr_valid.
REQ-014 busy  output  1  high while synchronized spi_csn is low.

Function
REQ-015 spi_clk, spi_csn and spi_sdi SHALL pass through SYNC_STAGES flops; edges detected on synchronized values; clk SHALL be at least 8x SPI clock frequency.
REQ-016 Register file: 64 x 8; 0x00 read-only DEVID; 0x32..0x37 read-only data (0x32=x[7:0], 0x33=x[15:8], 0x34=y[7:0], 0x35=y[15:8], 0x36=z[7:0], 0x37=z[15:8]); all others read/write.
REQ-017 State machine: IDLE, CMD, DATA; falling spi_csn -> CMD with bit counter 0; rising spi_csn from any state -> IDLE.
REQ-018 spi_sdi SHALL be sampled on each detected spi_clk rising edge into an 8-bit shift register; byte complete on eighth rising edge.
REQ-019 Command byte: bit7 R/W (1 = read), bit6 MB (1 = multi-byte), bits5:0 start address; on completion latch and go to DATA.
REQ-020 Write transfer: each complete data byte SHALL be written to the current address and wr_valid/wr_addr/wr_data pulsed in the cycle after the eighth rising edge.
REQ-021 Writes to read-only addresses SHALL be discarded with no wr_valid pulse.
REQ-022 Read transfer: register at the current address loaded into the output shifter on completion of the previous byte; spi_sdo SHALL update on each detected spi_clk falling edge, so bit7 is driven before the first rising edge of the data byte.
REQ-023 MB=1: address SHALL increment after each data byte, wrapping 0x3F -> 0x00; MB=0: address SHALL stay fixed for every data byte.
REQ-024 spi_sdo SHALL be 0 in IDLE, during CMD and during write transfers.
REQ-025 spi_csn deassert mid-byte SHALL discard the partial byte: no write, no wr_valid.
REQ-026 sample_valid with busy low SHALL update 0x32..0x37 in the next cycle.
REQ-027 sample_valid with busy high SHALL be captured in a one-entry pending buffer (a newer sample overwrites it) and applied the cycle after busy falls, so a burst read never mixes samples.
REQ-028 Simultaneous busy fall and sample_valid: the new sample SHALL win over any pending entry.

Reset
REQ-029 reset SHALL force IDLE, bit counter 0, spi_sdo 0, wr_valid 0, wr_addr 0, wr_data 0, busy 0, pending buffer empty, all registers 0x00 except 0x00 = DEVID.
REQ-030 Synchronizer flops SHALL reset to spi_clk=1, spi_csn=1, spi_sdi=0, so no false edge is detected on release.
REQ-031 Release of reset with spi_csn already low SHALL leave the block in IDLE until a fresh spi_csn falling edge.

Verification
REQ-032 Read 0x80 then one byte (clk 50 MHz, SPI 2 MHz) -> spi_sdo shifts 8'hE5; no wr_valid.
REQ-033 Write 0x24 then 0x20 -> one wr_valid with wr_addr 0x24, wr_data 0x20; subsequent read 0xA4 returns 0x20.
REQ-034 sample x=16'h1234, y=16'hFFFE, z=16'h0100; burst read 0xF2 then six bytes -> 34 12 FE FF 00 01.
REQ-035 Burst read 0xF2 with sample_valid (x=16'hAAAA) after byte 2 -> all six bytes from old sample; read after busy falls returns AA AA.
REQ-036 Multi-byte write 0x7F, 0x11, 0x22 -> wr_valid at 0x3F (0x11) then 0x00 discarded; register 0x00 still DEVID.
REQ-037 Write 0x05, 4 bits of 0x5A, spi_csn raised; then reset asserted mid-transfer -> no wr_valid; all registers at reset values.

Source files
------------

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 register responder modelled on a 3-axis accelerometer: 64 x 8 register file
// with a fixed device ID, read-only sample registers and a one-entry pending sample buffer.

module gsensor_spi_responder #(
    parameter logic [7:0]  DEVID       = 8'hE5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_csn,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        wr_valid,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sclk_prev_q, csn_prev_q;
    logic                   armed_q, armed_d;
    logic                   sclk_s, csn_s, sdi_s;
    logic                   sclk_rise, sclk_fall, csn_rise, csn_fall, byte_done;
    logic [7:0]             rx_byte;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic        rw_q, rw_d, mb_q, mb_d;
    logic [5:0]  addr_q, addr_d, addr_step;
    logic [7:0]  tx_q, tx_d;
    logic        sdo_q, sdo_d;
    logic        wr_valid_q, wr_valid_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  regs_q [64];
    logic [7:0]  regs_d [64];
    logic        pend_q, pend_d;
    logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;

    function automatic logic writable(input logic [5:0] a);
        return (a != 6'h00) && !((a >= 6'h32) && (a <= 6'h37));
    endfunction

    always_comb begin
        sclk_sync_d    = sclk_sync_q;
        csn_sync_d     = csn_sync_q;
        sdi_sync_d     = sdi_sync_q;
        fill_d         = fill_q;
        sclk_sync_d[0] = spi_clk;
        csn_sync_d[0]  = spi_csn;
        sdi_sync_d[0]  = spi_sdi;
        fill_d[0]      = 1'b1;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync_d[i] = sclk_sync_q[i-1];
            csn_sync_d[i]  = csn_sync_q[i-1];
            sdi_sync_d[i]  = sdi_sync_q[i-1];
            fill_d[i]      = fill_q[i-1];
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

    // Chip select only arms once a genuine high level has been seen after reset, so a
    // select already held low at reset release never starts a transfer.
    assign armed_d   = armed_q | (fill_q[SYNC_STAGES-1] & csn_s);
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign csn_fall  = armed_q & csn_prev_q & ~csn_s;
    assign busy      = armed_q & ~csn_s;

    assign rx_byte   = {shift_q, sdi_s};
    assign byte_done = (state_q != StIdle) && sclk_rise && (bit_cnt_q == 3'd7)
                       && !csn_rise && !csn_fall;
    assign addr_step = mb_q ? addr_q + 6'd1 : addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (csn_rise) begin
            state_d = StIdle;
        end else if (csn_fall) begin
            state_d = StCmd;
        end else if ((state_q == StCmd) && byte_done) begin
            state_d = StData;
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        mb_d       = mb_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        sdo_d      = sdo_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;
        pend_d     = pend_q;
        pend_x_d   = pend_x_q;
        pend_y_d   = pend_y_q;
        pend_z_d   = pend_z_q;

        if (csn_rise || csn_fall) begin
            bit_cnt_d = 3'd0;
            sdo_d     = 1'b0;
        end else if (state_q != StIdle) begin
            if (sclk_rise) begin
                shift_d   = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (byte_done && (state_q == StCmd)) begin
                rw_d   = rx_byte[7];
                mb_d   = rx_byte[6];
                addr_d = rx_byte[5:0];
                tx_d   = regs_q[rx_byte[5:0]];
            end else if (byte_done) begin
                if (!rw_q && writable(addr_q)) begin
                    regs_d[addr_q] = rx_byte;
                    wr_valid_d     = 1'b1;
                    wr_addr_d      = addr_q;
                    wr_data_d      = rx_byte;
                end
                addr_d = addr_step;
                tx_d   = regs_q[addr_step];
            end
            if (sclk_fall) begin
                if ((state_q == StData) && rw_q) begin
                    sdo_d = tx_q[7];
                    tx_d  = {tx_q[6:0], 1'b0};
                end else begin
                    sdo_d = 1'b0;
                end
            end
        end

        // Data registers stay frozen while selected so a burst read never mixes samples.
        if (!busy) begin
            if (sample_valid) begin
                regs_d[6'h32] = sample_x[7:0];
                regs_d[6'h33] = sample_x[15:8];
                regs_d[6'h34] = sample_y[7:0];
                regs_d[6'h35] = sample_y[15:8];
                regs_d[6'h36] = sample_z[7:0];
                regs_d[6'h37] = sample_z[15:8];
                pend_d        = 1'b0;
            end else if (pend_q) begin
                regs_d[6'h32] = pend_x_q[7:0];
                regs_d[6'h33] = pend_x_q[15:8];
                regs_d[6'h34] = pend_y_q[7:0];
                regs_d[6'h35] = pend_y_q[15:8];
                regs_d[6'h36] = pend_z_q[7:0];
                regs_d[6'h37] = pend_z_q[15:8];
                pend_d        = 1'b0;
            end
        end else if (sample_valid) begin
            pend_d   = 1'b1;
            pend_x_d = sample_x;
            pend_y_d = sample_y;
            pend_z_d = sample_z;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '1;
            csn_sync_q  <= '1;
            sdi_sync_q  <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b1;
            csn_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            rw_q        <= 1'b0;
            mb_q        <= 1'b0;
            addr_q      <= 6'd0;
            tx_q        <= 8'd0;
            sdo_q       <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'd0;
            pend_q      <= 1'b0;
            pend_x_q    <= 16'd0;
            pend_y_q    <= 16'd0;
            pend_z_q    <= 16'd0;
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= (i == 0) ? DEVID : 8'h00;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            csn_sync_q  <= csn_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            fill_q      <= fill_d;
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            mb_q        <= mb_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            sdo_q       <= sdo_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pend_q      <= pend_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_z_q    <= pend_z_d;
            regs_q      <= regs_d;
        end
    end

    assign spi_sdo  = sdo_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Directed bench for gsensor_spi_responder: SPI initiator tasks at 2 MHz against a 50 MHz
// system clock, with read/write scoreboards checked through immediate assertions.

module tb_gsensor_spi_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_clk, spi_csn, spi_sdi, spi_sdo;
    logic        sample_valid;
    logic [15:0] sample_x, sample_y, sample_z;
    logic        wr_valid, busy;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [13:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [13:0] mon_e;
    logic [7:0]  rx;

    gsensor_spi_responder #(
        .DEVID      (8'hE5),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_csn     (spi_csn),
        .spi_sdi     (spi_sdi),
        .spi_sdo     (spi_sdo),
        .sample_valid(sample_valid),
        .sample_x    (sample_x),
        .sample_y    (sample_y),
        .sample_z    (sample_z),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Every committed write must match the head of the write scoreboard.
    always @(negedge clk) begin
        if (!reset && wr_valid) begin
            n_assert++;
            assert (exp_wr.size() != 0) else begin
                n_fail++;
                $error("FAIL wr_unexpected: observed addr %h data %h required no write",
                       wr_addr, wr_data);
            end
            if (exp_wr.size() != 0) begin
                mon_e = exp_wr.pop_front();
                check("wr_addr", {2'b00, wr_addr}, {2'b00, mon_e[13:8]});
                check("wr_data", wr_data, mon_e[7:0]);
            end
        end
    end

    task automatic pop_rd(input string tag, input logic [7:0] obs);
        n_assert++;
        assert (exp_rd.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: observed %h required a scoreboard entry", tag, obs);
        end
        if (exp_rd.size() != 0) check(tag, obs, exp_rd.pop_front());
    endtask

    // Edges land 5 ns off the system clock edges so nothing races the DUT sampling.
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            spi_clk = 1'b0;
            spi_sdi = tx[i];
            #250;
            r[i]    = spi_sdo;
            spi_clk = 1'b1;
            #250;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            spi_clk = 1'b0;
            spi_sdi = tx[i];
            #250;
            spi_clk = 1'b1;
            #250;
        end
    endtask

    task automatic spi_begin();
        @(negedge clk);
        #5;
        spi_csn = 1'b0;
        #250;
    endtask

    task automatic spi_end();
        spi_csn = 1'b1;
        spi_sdi = 1'b0;
        #500;
    endtask

    task automatic spi_read(input string tag, input logic [7:0] cmd, input int n);
        logic [7:0] r;
        spi_begin();
        spi_byte(cmd, r);
        check({tag, "_cmd_sdo"}, r, 8'h00);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, r);
            pop_rd(tag, r);
        end
        spi_end();
    endtask

    task automatic spi_write(input string tag, input logic [7:0] cmd, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
        logic [7:0] r;
        spi_begin();
        spi_byte(cmd, r);
        check({tag, "_cmd_sdo"}, r, 8'h00);
        spi_byte(d0, r);
        check({tag, "_d0_sdo"}, r, 8'h00);
        if (n > 1) begin
            spi_byte(d1, r);
            check({tag, "_d1_sdo"}, r, 8'h00);
        end
        spi_end();
    endtask

    task automatic push6(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        exp_rd.push_back(x[7:0]);
        exp_rd.push_back(x[15:8]);
        exp_rd.push_back(y[7:0]);
        exp_rd.push_back(y[15:8]);
        exp_rd.push_back(z[7:0]);
        exp_rd.push_back(z[15:8]);
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z);
        @(negedge clk);
        sample_x     = x;
        sample_y     = y;
        sample_z     = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        #5;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sdo"}, {7'd0, spi_sdo}, 8'h00);
        check({tag, "_wr_valid"}, {7'd0, wr_valid}, 8'h00);
        check({tag, "_wr_addr"}, {2'b00, wr_addr}, 8'h00);
        check({tag, "_wr_data"}, wr_data, 8'h00);
        check({tag, "_busy"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        reset        = 1'b1;
        spi_clk      = 1'b1;
        spi_csn      = 1'b0;
        spi_sdi      = 1'b0;
        sample_valid = 1'b0;
        sample_x     = 16'h0000;
        sample_y     = 16'h0000;
        sample_z     = 16'h0000;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_idle_outputs("post_reset");

        // Select held low across reset release: clocked bytes must be ignored.
        #5;
        spi_byte(8'h05, rx);
        spi_byte(8'h77, rx);
        check("stale_csn_busy", {7'd0, busy}, 8'h00);
        spi_end();
        exp_rd.push_back(8'h00);
        spi_read("stale_csn_rd05", 8'h85, 1);

        exp_rd.push_back(8'hE5);
        spi_read("devid", 8'h80, 1);

        exp_wr.push_back({6'h24, 8'h20});
        spi_write("wr24", 8'h24, 8'h20, 8'h00, 1);
        check("wr24_consumed", 8'(exp_wr.size()), 8'd0);
        exp_rd.push_back(8'h20);
        spi_read("rd24", 8'hA4, 1);
        exp_rd.push_back(8'h20);
        exp_rd.push_back(8'h20);
        spi_read("rd24_fixed_addr", 8'hA4, 2);

        pulse_sample(16'h1234, 16'hFFFE, 16'h0100);
        push6(16'h1234, 16'hFFFE, 16'h0100);
        spi_read("burst", 8'hF2, 6);

        // New sample arriving mid-burst must not disturb the bytes still to be read.
        push6(16'h1234, 16'hFFFE, 16'h0100);
        spi_begin();
        spi_byte(8'hF2, rx);
        check("burst_hold_cmd_sdo", rx, 8'h00);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h00, rx);
            pop_rd("burst_hold", rx);
        end
        pulse_sample(16'hAAAA, 16'hBBBB, 16'hCCCC);
        check("burst_hold_busy", {7'd0, busy}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            pop_rd("burst_hold", rx);
        end
        spi_end();
        push6(16'hAAAA, 16'hBBBB, 16'hCCCC);
        spi_read("pending_applied", 8'hF2, 6);

        // Pending entry vs fresh sample in the cycle busy falls: fresh sample wins.
        spi_begin();
        spi_byte(8'hF2, rx);
        exp_rd.push_back(8'hAA);
        spi_byte(8'h00, rx);
        pop_rd("race_burst", rx);
        pulse_sample(16'h1111, 16'h2222, 16'h3333);
        exp_rd.push_back(8'hAA);
        spi_byte(8'h00, rx);
        pop_rd("race_burst", rx);
        spi_csn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("race_busy_fell", {7'd0, busy}, 8'h00);
        sample_x     = 16'h4444;
        sample_y     = 16'h5555;
        sample_z     = 16'h6666;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        push6(16'h4444, 16'h5555, 16'h6666);
        spi_read("race_new_wins", 8'hF2, 6);

        exp_wr.push_back({6'h3F, 8'h11});
        spi_write("wr_wrap", 8'h7F, 8'h11, 8'h22, 2);
        exp_rd.push_back(8'hE5);
        spi_read("devid_kept", 8'h80, 1);
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'hE5);
        spi_read("rd_wrap", 8'hFF, 2);

        spi_begin();
        spi_byte(8'h05, rx);
        check("partial_cmd_sdo", rx, 8'h00);
        spi_bits(8'h5A, 4);
        spi_end();
        exp_rd.push_back(8'h00);
        spi_read("partial_rd05", 8'h85, 1);

        // Reset in the middle of a write byte.
        spi_begin();
        spi_byte(8'h3F, rx);
        spi_bits(8'h5A, 4);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        spi_csn = 1'b1;
        spi_clk = 1'b1;
        spi_sdi = 1'b0;
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_idle_outputs("after_mid_reset");
        exp_rd.push_back(8'h00);
        spi_read("rst_rd24", 8'hA4, 1);
        exp_rd.push_back(8'h00);
        spi_read("rst_rd3f", 8'hBF, 1);
        push6(16'h0000, 16'h0000, 16'h0000);
        spi_read("rst_data", 8'hF2, 6);
        exp_rd.push_back(8'hE5);
        spi_read("rst_devid", 8'h80, 1);

        repeat (10) @(negedge clk);
        check("wr_scoreboard_empty", 8'(exp_wr.size()), 8'd0);
        check("rd_scoreboard_empty", 8'(exp_rd.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
